// File: rtl/mem_stage_sram_ctrl_if.sv
// Pipeline-side bundle between EXE/MEM, the data-memory controller and MEM/WB.
// The master is the pipeline (request side), the slave is the SRAM controller.
interface mem_stage_sram_ctrl_if;
  logic        mem_r_en;
  logic        mem_w_en;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] mem_read_value;
  logic        ready;
  logic        align_err;

  modport master (
    output mem_r_en, mem_w_en, addr, wdata,
    input  mem_read_value, ready, align_err
  );

  modport slave (
    input  mem_r_en, mem_w_en, addr, wdata,
    output mem_read_value, ready, align_err
  );
endinterface

// File: rtl/mem_stage_sram_ctrl.sv
// MEM-stage controller: each 32-bit load/store becomes two fixed-wait 16-bit SRAM transfers.
// Optional feature macro: MEM_ALIGN_CHECK_EN (misaligned requests finish at once with align_err).
module mem_stage_sram_ctrl #(
  parameter int ADDR_BASE   = 1024,
  parameter int SRAM_AW     = 18,
  parameter int WAIT_CYCLES = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_stage_sram_ctrl_if.slave bus,
  output logic [SRAM_AW-1:0]   sram_addr,
  output logic [15:0]          sram_wdata,
  output logic                 sram_we_n,
  input  logic [15:0]          sram_rdata
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  localparam logic [31:0] BASE       = 32'(ADDR_BASE);
  localparam logic [3:0]  LAST_COUNT = 4'(WAIT_CYCLES - 1);

  state_t             state;
  logic [3:0]         count;
  logic               op_write;
  logic [15:0]        wdata_hi;
  logic [15:0]        low_half;
  logic [31:0]        read_value;
  logic               request;
  logic [31:0]        word_offset;
  logic [SRAM_AW-2:0] word_idx;
  logic               unused_bits;

  assign request = bus.mem_r_en | bus.mem_w_en;

  // Low address bits are dropped first so an unchecked misaligned access is word-truncated.
  assign word_offset = {bus.addr[31:2], 2'b00} - BASE;
  assign word_idx    = word_offset[SRAM_AW:2];
  assign unused_bits = ^{word_offset[31:SRAM_AW+1], word_offset[1:0], bus.addr[1:0]};

  assign bus.ready          = (state == DONE) | ((state == IDLE) & ~request);
  assign bus.mem_read_value = read_value;

`ifdef MEM_ALIGN_CHECK_EN
  logic align_err_q;
  assign bus.align_err = align_err_q;
`else
  assign bus.align_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      count      <= '0;
      op_write   <= 1'b0;
      wdata_hi   <= '0;
      low_half   <= '0;
      read_value <= '0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      sram_we_n  <= 1'b1;
`ifdef MEM_ALIGN_CHECK_EN
      align_err_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (request) begin
            op_write <= bus.mem_w_en;
            wdata_hi <= bus.wdata[31:16];
            count    <= '0;
`ifdef MEM_ALIGN_CHECK_EN
            if (bus.addr[1:0] != 2'b00) begin
              state       <= DONE;
              align_err_q <= 1'b1;
              if (!bus.mem_w_en) read_value <= '0;
            end else
`endif
            begin
              state     <= LOW;
              sram_addr <= {word_idx, 1'b0};
              sram_we_n <= ~bus.mem_w_en;
              if (bus.mem_w_en) sram_wdata <= bus.wdata[15:0];
            end
          end
        end

        LOW: begin
          if (count == LAST_COUNT) begin
            count        <= '0;
            state        <= HIGH;
            sram_addr[0] <= 1'b1;
            if (op_write) sram_wdata <= wdata_hi;
            else          low_half   <= sram_rdata;
          end else begin
            count <= count + 4'd1;
          end
        end

        HIGH: begin
          if (count == LAST_COUNT) begin
            count     <= '0;
            state     <= DONE;
            sram_we_n <= 1'b1;
            if (!op_write) read_value <= {sram_rdata, low_half};
          end else begin
            count <= count + 4'd1;
          end
        end

        DONE: begin
          state <= IDLE;
`ifdef MEM_ALIGN_CHECK_EN
          align_err_q <= 1'b0;
`endif
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_stage_sram_ctrl.md
# mem_stage_sram_ctrl

Memory-stage data-memory controller that produces the read value and write-back freeze for the MEM/WB pipeline register. It takes the load/store request carried by the EXE/MEM register and performs each 32-bit access as two 16-bit transfers on an external asynchronous SRAM with a fixed wait count. While an access is in flight it holds `ready` low so the upstream pipeline freezes. The MEM/WB register captures `mem_read_value` in the cycle `ready` returns high.

## Interface
- `ADDR_BASE`, 1024: byte address that maps to SRAM word 0.
- `SRAM_AW`, 18: SRAM half-word address width.
- `WAIT_CYCLES`, 5: clocks per 16-bit transfer; legal range 1..15.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `mem_r_en` in 1: load request, level, from EXE/MEM.
- `mem_w_en` in 1: store request, level, from EXE/MEM.
- `addr` in 32: byte address (ALU result).
- `wdata` in 32: store data.
- `mem_read_value` out 32: load result, registered.
- `ready` out 1: combinational; low means freeze the pipeline.
- `align_err` out 1: misaligned-access flag (see Configuration).
- `sram_addr` out SRAM_AW: half-word address, registered.
- `sram_wdata` out 16: write half-word, registered.
- `sram_we_n` out 1: write strobe, active-low, registered.
- `sram_rdata` in 16: read half-word from SRAM.

## Operation
- States: IDLE, LOW, HIGH, DONE. A 4-bit wait counter runs inside LOW and HIGH.
- IDLE with `mem_r_en|mem_w_en`:
  - Latch the op, `addr` and `wdata`. If both enables are high, write wins.
  - Go to LOW with the counter at 0.
- Word index is `(addr_latched - ADDR_BASE) >> 2`, computed mod 2^32.
- LOW drives `sram_addr = {idx[SRAM_AW-2:0], 1'b0}`. HIGH drives the same with LSB 1. Upper index bits are dropped, so addresses wrap.
- Writes: LOW drives `sram_wdata = wdata[15:0]` and HIGH drives `wdata[31:16]`. `sram_we_n` is 0 for every cycle of LOW and HIGH.
- Reads: `sram_we_n` stays 1. `sram_rdata` is sampled on the last wait cycle of LOW (low half) and of HIGH (high half).
- Counter: each LOW/HIGH phase lasts exactly WAIT_CYCLES clocks. On `count == WAIT_CYCLES-1`, move LOW→HIGH or HIGH→DONE and clear the counter.
- DONE lasts one cycle and always returns to IDLE:
  - For a read, `mem_read_value` equals `{high_half, low_half}`.
  - `mem_read_value` holds its value until the next read completes. Writes leave it unchanged.
- `ready = (state==DONE) | (state==IDLE & !mem_r_en & !mem_w_en)`.
- Requests are latched once. Request lines changing during LOW/HIGH are ignored, and the access completes.
- A request still asserted in the IDLE cycle after DONE is treated as a new access. Upstream has advanced by then, so this is the next instruction.

## Timing
- Reset (async, `rst`=0):
  - State goes to IDLE immediately, counter to 0.
  - `mem_read_value`=0, `sram_addr`=0, `sram_wdata`=0, `sram_we_n`=1, `align_err`=0.
  - `ready` follows its IDLE equation.
- Reset mid-access aborts the access. `sram_we_n` rises without waiting for a clock edge. No partial data reaches `mem_read_value`.
- Request seen in IDLE at cycle 0:
  - LOW occupies cycles 1..W and HIGH occupies W+1..2W.
  - DONE is cycle 2W+1, with `ready`=1 and data valid.
  - `ready` is low for 2W+1 cycles (0..2W). W is WAIT_CYCLES.
- With no request, `ready` stays 1 and zero latency is added.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined:
  - In IDLE, a request with `addr[1:0]!=0` skips the SRAM and goes straight to DONE next cycle.
  - `align_err`=1 during that DONE only.
  - For a read, `mem_read_value` is set to 0. For a write, the SRAM is untouched.
- Not defined: `addr[1:0]` is ignored (word-truncated) and `align_err` is tied 0.

## Test plan
- Reset, then W=5, write `addr`=1028 `wdata`=0xDEADBEEF:
  - `sram_addr`=2 with `sram_wdata`=0xBEEF for 5 cycles, then `sram_addr`=3 with 0xDEAD for 5 cycles, `we_n` low throughout.
  - `ready` is low for 11 cycles.
- Read `addr`=1028 with SRAM model returning 0xBEEF/0xDEAD → `mem_read_value`=0xDEADBEEF in DONE (cycle 11), held through later writes.
- Back-to-back reads at 1024 and 1032 → two 11-cycle freezes separated by a single `ready`=1 cycle.
- `mem_r_en` and `mem_w_en` both high → write performed, `mem_read_value` unchanged.
- `rst` low at cycle 3 of a write → `sram_we_n`=1 before the next edge, state IDLE, `mem_read_value`=0.
- With `MEM_ALIGN_CHECK_EN`, read `addr`=1026 → DONE next cycle with `align_err`=1, `mem_read_value`=0, no `sram_addr` change. Without the macro, the same read returns word 1024.
